// File: rtl/reset_req_gen_pkg.sv
// Shared types for the reset request generator: FSM state encoding and
// the bit positions inside RST_CAUSE.
package reset_req_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int CAUSE_W   = 3;
  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_DBG = 1;
  localparam int CAUSE_WDT = 2;

endpackage

// File: rtl/reset_req_gen_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff #(
  parameter int         WIDTH   = 1,
  parameter logic [0:0] RST_VAL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= {WIDTH{RST_VAL}};
      sync_q <= {WIDTH{RST_VAL}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_req_gen.sv
// Turns SW/debug/watchdog reset requests into a handshaked, minimum-width
// active-low request to the reset controller, recording the cause.
module reset_req_gen
  import reset_req_gen_pkg::*;
#(
  parameter int MIN_PULSE   = 16,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               SW_RST_REQ,
  input  logic               DBG_RST_REQ,
  input  logic               WDT_EXPIRE,
  input  logic               CAUSE_CLR,
  input  logic               FABRIC_RESET_N,
  output logic               EXT_RST_N,
  output logic               BUSY,
  output logic [CAUSE_W-1:0] RST_CAUSE,
  output logic               ERR_TIMEOUT
);

  localparam logic [15:0] MIN_LD = 16'(MIN_PULSE - 1);
  localparam logic [15:0] ACK_LD = 16'(ACK_TIMEOUT - 1);

  logic               fab_s;
  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               err_q, err_d;
  logic               ext_rst_n_q;
  logic               busy_q;
  logic [CAUSE_W-1:0] req_vec;
  logic               err_set;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_fab_sync (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .d_i    (FABRIC_RESET_N),
    .q_o    (fab_s)
  );

  always_comb begin
    req_vec            = '0;
    req_vec[CAUSE_SW]  = SW_RST_REQ;
    req_vec[CAUSE_DBG] = DBG_RST_REQ;
    req_vec[CAUSE_WDT] = WDT_EXPIRE;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d = ST_ASSERT;
          cnt_d   = ACK_LD;
        end
      end
      ST_ASSERT: begin
        if (!fab_s) begin
          state_d = ST_HOLD;
          cnt_d   = MIN_LD;
        end else if (cnt_q == 16'd0) begin
          err_set = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = MIN_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_RELEASE;
          cnt_d   = ACK_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_RELEASE: begin
        if (fab_s) begin
          state_d = ST_DONE;
        end else if (cnt_q == 16'd0) begin
          err_set = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Set beats clear: the request term is OR-ed in after masking.
  assign cause_d = (cause_q & ~{CAUSE_W{CAUSE_CLR}}) | req_vec;
  assign err_d   = (err_q & ~CAUSE_CLR) | err_set;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      cause_q     <= '0;
      err_q       <= 1'b0;
      ext_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      err_q       <= err_d;
      ext_rst_n_q <= !((state_d == ST_ASSERT) || (state_d == ST_HOLD));
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign EXT_RST_N   = ext_rst_n_q;
  assign BUSY        = busy_q;
  assign RST_CAUSE   = cause_q;
  assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_reset_req_gen.sv
// Scoreboard bench: stimulus pushes the expected sequence summary, a monitor
// measures each completed sequence and compares.
module tb_reset_req_gen;

  localparam int ACK_LAT = 3;
  localparam int REL_LAT = 4;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SW_RST_REQ = 1'b0;
  logic       DBG_RST_REQ = 1'b0;
  logic       WDT_EXPIRE = 1'b0;
  logic       CAUSE_CLR = 1'b0;
  logic       FABRIC_RESET_N = 1'b1;
  logic       EXT_RST_N;
  logic       BUSY;
  logic [2:0] RST_CAUSE;
  logic       ERR_TIMEOUT;

  reset_req_gen #(.MIN_PULSE(16), .ACK_TIMEOUT(256)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .SW_RST_REQ     (SW_RST_REQ),
    .DBG_RST_REQ    (DBG_RST_REQ),
    .WDT_EXPIRE     (WDT_EXPIRE),
    .CAUSE_CLR      (CAUSE_CLR),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .EXT_RST_N      (EXT_RST_N),
    .BUSY           (BUSY),
    .RST_CAUSE      (RST_CAUSE),
    .ERR_TIMEOUT    (ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int low;
    int cause;
    int err;
    int gap;   // -1: idle gap before this sequence not checked
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   seq_starts = 0;
  bit   ack_en = 1'b1;
  bit   mon_skip = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  // Reset-controller model: acknowledge and release with fixed latencies.
  initial begin : fabric_model
    bit ext_prev = 1'b1;
    int a = 0;
    int r = 0;
    forever begin
      @(negedge CLK);
      if (ext_prev && !EXT_RST_N) begin
        if (ack_en) a = ACK_LAT;
      end else if (a > 0) begin
        a--;
        if (a == 0) FABRIC_RESET_N = 1'b0;
      end
      if (!ext_prev && EXT_RST_N) begin
        r = REL_LAT;
      end else if (r > 0) begin
        r--;
        if (r == 0) FABRIC_RESET_N = 1'b1;
      end
      ext_prev = EXT_RST_N;
    end
  end

  initial begin : monitor
    bit   ext_prev = 1'b1;
    bit   busy_prev = 1'b0;
    int   low_len = 0;
    int   idle_len = 1000;
    int   last_gap = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (BUSY && !busy_prev) begin
        last_gap = idle_len;
        seq_starts++;
      end
      if (!BUSY) idle_len++; else idle_len = 0;
      if (!EXT_RST_N) low_len = ext_prev ? 1 : low_len + 1;
      if (!BUSY && busy_prev) begin
        if (mon_skip) begin
          mon_skip = 1'b0;
        end else if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sequence: got low=%0d expected none", low_len);
        end else begin
          e = sb_q.pop_front();
          chk("seq_low_cycles", low_len, e.low);
          chk("seq_cause", int'(RST_CAUSE), e.cause);
          chk("seq_err_timeout", int'(ERR_TIMEOUT), e.err);
          if (e.gap >= 0) chk("seq_idle_gap", last_gap, e.gap);
        end
      end
      ext_prev  = EXT_RST_N;
      busy_prev = BUSY;
    end
  end

  function automatic exp_t mk(input int low, input int cause, input int err, input int gap);
    exp_t e;
    e.low = low; e.cause = cause; e.err = err; e.gap = gap;
    return e;
  endfunction

  task automatic wait_done(input string name, input int max_cyc);
    int n = 0;
    while ((sb_q.size() != 0 || BUSY) && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    if (sb_q.size() != 0 || BUSY) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0d expected 0/0", name, sb_q.size(), BUSY);
      sb_q.delete();
    end
  endtask

  task automatic clr_cause();
    @(negedge CLK); CAUSE_CLR = 1'b1;
    @(negedge CLK); CAUSE_CLR = 1'b0;
  endtask

  localparam int NORM_LOW = ACK_LAT + 2 + 17;   // 22
  localparam int TO_LOW   = 256 + 16;           // 272

  initial begin : stimulus
    int n;
    // Power-on reset values
    repeat (3) @(negedge CLK);
    chk("rst_ext_rst_n", int'(EXT_RST_N), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_cause", int'(RST_CAUSE), 0);
    chk("rst_err", int'(ERR_TIMEOUT), 0);
    RESET_N = 1'b1;

    // SW request sampled at the edge that makes cyc=10
    n = 0;
    while (cyc != 9 && n < 50) begin @(negedge CLK); n++; end
    sb_q.push_back(mk(NORM_LOW, 3'b001, 0, -1));
    chk("sw_ext_before", int'(EXT_RST_N), 1);
    SW_RST_REQ = 1'b1;
    @(negedge CLK); SW_RST_REQ = 1'b0;
    chk("sw_ext_after_1cyc", int'(EXT_RST_N), 0);
    chk("sw_busy_after_1cyc", int'(BUSY), 1);
    wait_done("sw", 200);
    repeat (10) @(negedge CLK);
    chk("sw_no_restart_busy", int'(BUSY), 0);
    clr_cause();
    chk("clr_cause", int'(RST_CAUSE), 0);

    // No acknowledge: handshake timeout
    ack_en = 1'b0;
    sb_q.push_back(mk(TO_LOW, 3'b001, 1, -1));
    @(negedge CLK); SW_RST_REQ = 1'b1;
    @(negedge CLK); SW_RST_REQ = 1'b0;
    wait_done("timeout", 800);
    ack_en = 1'b1;
    repeat (10) @(negedge CLK);
    chk("timeout_err_sticky", int'(ERR_TIMEOUT), 1);

    // Clear and SW request in the same cycle: set wins, error clears
    sb_q.push_back(mk(NORM_LOW, 3'b001, 0, -1));
    @(negedge CLK); SW_RST_REQ = 1'b1; CAUSE_CLR = 1'b1;
    @(negedge CLK); SW_RST_REQ = 1'b0; CAUSE_CLR = 1'b0;
    chk("clr_sw_cause", int'(RST_CAUSE), 3'b001);
    chk("clr_sw_err", int'(ERR_TIMEOUT), 0);
    wait_done("clr_sw", 200);
    repeat (10) @(negedge CLK);
    clr_cause();

    // Simultaneous SW+DBG, WDT pulse in HOLD: one sequence, all causes
    sb_q.push_back(mk(NORM_LOW, 3'b111, 0, -1));
    @(negedge CLK); SW_RST_REQ = 1'b1; DBG_RST_REQ = 1'b1;
    @(negedge CLK); SW_RST_REQ = 1'b0; DBG_RST_REQ = 1'b0;
    chk("simul_cause", int'(RST_CAUSE), 3'b011);
    repeat (11) @(negedge CLK);
    WDT_EXPIRE = 1'b1;
    @(negedge CLK); WDT_EXPIRE = 1'b0;
    wait_done("simul", 200);
    repeat (30) @(negedge CLK);
    chk("simul_single_seq_busy", int'(BUSY), 0);
    clr_cause();

    // WDT held: back-to-back sequences, one DONE plus one IDLE cycle apart
    for (int i = 0; i < 3; i++) sb_q.push_back(mk(NORM_LOW, 3'b100, 0, (i == 0) ? -1 : 1));
    n = seq_starts;
    @(negedge CLK); WDT_EXPIRE = 1'b1;
    begin
      int k = 0;
      while (seq_starts < n + 3 && k < 300) begin @(negedge CLK); k++; end
    end
    WDT_EXPIRE = 1'b0;
    wait_done("wdt_b2b", 300);
    repeat (10) @(negedge CLK);
    chk("wdt_b2b_seq_count", seq_starts - n, 3);
    clr_cause();

    // Asynchronous reset in HOLD aborts without a clock edge
    @(negedge CLK); SW_RST_REQ = 1'b1;
    @(negedge CLK); SW_RST_REQ = 1'b0;
    repeat (12) @(negedge CLK);
    chk("abort_in_hold_ext", int'(EXT_RST_N), 0);
    #2;
    mon_skip = 1'b1;
    RESET_N = 1'b0;
    #1;
    chk("abort_ext_rst_n", int'(EXT_RST_N), 1);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_cause", int'(RST_CAUSE), 0);
    chk("abort_err", int'(ERR_TIMEOUT), 0);
    #1;
    RESET_N = 1'b1;
    repeat (15) @(negedge CLK);

    // Recovery after abort
    sb_q.push_back(mk(NORM_LOW, 3'b001, 0, -1));
    @(negedge CLK); SW_RST_REQ = 1'b1;
    @(negedge CLK); SW_RST_REQ = 1'b0;
    wait_done("recover", 200);
    repeat (5) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
